sraa_qc_accum: RTL

SRAA_QC_ACCUM -- requirements
Module: sraa_qc_accum

---
 rtl/sraa_qc_accum.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sraa_qc_accum.sv
// sraa_qc_accum -- serial quasi-cyclic parity accumulator.
// For each of SEGMENTS info segments, the first row of a WIDTH x WIDTH generator
// circulant is loaded into a rotating register g. Every accepted info bit XORs
// g into the accumulator when the bit is 1, and g then rotates right by one.
// After the last bit of the last segment, the accumulator is offered on
// parity_out with a valid/ready handshake.
// Optional feature: define SRAA_PROTOCOL_ERR_EN to add a sticky protocol
// error output err (start while busy, or info_valid outside ACCUM).
module sraa_qc_accum #(
  parameter int WIDTH    = 16,
  parameter int SEGMENTS = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] gen_in,
  input  logic             gen_valid,
  output logic             gen_ready,
  input  logic             info_bit,
  input  logic             info_valid,
  output logic             info_ready,
  output logic [WIDTH-1:0] parity_out,
  output logic             parity_valid,
  input  logic             parity_ready,
  output logic             busy
`ifdef SRAA_PROTOCOL_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int SEG_W = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEGMENTS - 1);
  localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_GEN = 2'd1,
    ACCUM    = 2'd2,
    OUTPUT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SEG_W-1:0] seg_cnt_q, seg_cnt_d;

  // Rotate right by one position: the circulant's next row.
  function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  // Handshake flags depend only on the current state so they never overlap.
  assign gen_ready    = (state_q == LOAD_GEN);
  assign info_ready   = (state_q == ACCUM);
  assign parity_valid = (state_q == OUTPUT);
  assign busy         = (state_q != IDLE);
  assign parity_out   = acc_q;

  // Next-state and datapath update for the encoder sequence.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    g_d       = g_q;
    bit_cnt_d = bit_cnt_q;
    seg_cnt_d = seg_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_GEN;
          acc_d     = {WIDTH{1'b0}};
          seg_cnt_d = {SEG_W{1'b0}};
        end else begin
          state_d   = IDLE;
        end
      end
      LOAD_GEN: begin
        if (gen_valid) begin
          g_d       = gen_in;
          bit_cnt_d = {BIT_W{1'b0}};
          state_d   = ACCUM;
        end else begin
          state_d   = LOAD_GEN;
        end
      end
      ACCUM: begin
        if (info_valid) begin
          acc_d = acc_q ^ (g_q & {WIDTH{info_bit}});
          g_d   = rotr1(g_q);
          if (bit_cnt_q == BIT_LAST) begin
            // Counter holds at its last value; the next gen load resets it.
            if (seg_cnt_q == SEG_LAST) begin
              state_d = OUTPUT;
            end else begin
              seg_cnt_d = seg_cnt_q + SEG_ONE;
              state_d   = LOAD_GEN;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      OUTPUT: begin
        // A start arriving with the handshake is deliberately ignored.
        if (parity_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      acc_q     <= {WIDTH{1'b0}};
      g_q       <= {WIDTH{1'b0}};
      bit_cnt_q <= {BIT_W{1'b0}};
      seg_cnt_q <= {SEG_W{1'b0}};
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      g_q       <= g_d;
      bit_cnt_q <= bit_cnt_d;
      seg_cnt_q <= seg_cnt_d;
    end
  end

`ifdef SRAA_PROTOCOL_ERR_EN
  logic err_q, err_d;

  // Sticky protocol error: start while busy or info offered outside ACCUM.
  always_comb begin
    err_d = err_q;
    if ((start && busy) || (info_valid && (state_q != ACCUM))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register; only clear removes it.
  always_ff @(posedge clk) begin
    if (clear) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
